// File: rtl/branch_unit.sv
// Branch-resolution stage: decodes the branch code against the ALU flags and
// registers the next-PC target, taken strobe and link-register write enable.
module branch_unit #(
   parameter int PC_W   = 11,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        bcode,
   input  logic              zflag,
   input  logic              carryflag,
   input  logic              signflag,
   input  logic              ovfflag,
   input  logic [DATA_W-1:0] L,
   input  logic [DATA_W-1:0] rega,
   output logic [PC_W-1:0]   PC,
   output logic              branch_control,
   output logic              write_reg
);

   logic            taken;
   logic            is_call;
   logic            cond;
   logic [PC_W-1:0] target;

   // Operand bits above the PC width are deliberately discarded.
   logic unused_high_bits;
   assign unused_high_bits = ^{L[DATA_W-1:PC_W], rega[DATA_W-1:PC_W]};

   always_comb begin
      taken   = 1'b0;
      is_call = 1'b0;
      cond    = 1'b0;
      target  = L[PC_W-1:0];
      if (bcode[5:4] == 2'b10) begin
         if (!bcode[3]) begin
            case (bcode[2:0])
               3'd0: begin
                  taken  = 1'b1;
                  target = rega[PC_W-1:0];
               end
               3'd1: taken = 1'b1;
               3'd2: begin
                  taken   = 1'b1;
                  is_call = 1'b1;
               end
               default: taken = 1'b0;
            endcase
         end else begin
            // bcode[2:1] picks the flag, bcode[0] inverts the sense of the test.
            case (bcode[2:1])
               2'd0:    cond = zflag;
               2'd1:    cond = carryflag;
               2'd2:    cond = signflag;
               default: cond = ovfflag;
            endcase
            taken = cond ^ bcode[0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         PC             <= '0;
         branch_control <= 1'b0;
         write_reg      <= 1'b0;
      end else begin
         branch_control <= taken;
         write_reg      <= taken & is_call;
         if (taken)
            PC <= target;
      end
   end

endmodule

// File: tb/tb_branch_unit.sv
// Directed scoreboard bench for branch_unit: each step queues the expected
// registered outputs and checks them one clock later.
module tb_branch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  bcode;
   logic        zflag, carryflag, signflag, ovfflag;
   logic [31:0] L, rega;
   logic [10:0] PC;
   logic        branch_control, write_reg;

   typedef struct {
      string       tag;
      logic [10:0] pc;
      logic        bc;
      logic        wr;
   } exp_t;

   exp_t exp_q[$];
   logic [10:0] model_pc;
   int total = 0;
   int bad   = 0;

   branch_unit #(.PC_W(11), .DATA_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .bcode          (bcode),
      .zflag          (zflag),
      .carryflag      (carryflag),
      .signflag       (signflag),
      .ovfflag        (ovfflag),
      .L              (L),
      .rega           (rega),
      .PC             (PC),
      .branch_control (branch_control),
      .write_reg      (write_reg)
   );

   always #5 clk = ~clk;

   // Reference condition table written out code by code.
   function automatic logic model_taken(input logic [5:0] c, input logic z, input logic cy,
                                        input logic s, input logic v);
      case (c)
         6'b100000, 6'b100001, 6'b100010: return 1'b1;
         6'b101000: return z;
         6'b101001: return !z;
         6'b101010: return cy;
         6'b101011: return !cy;
         6'b101100: return s;
         6'b101101: return !s;
         6'b101110: return v;
         6'b101111: return !v;
         default:   return 1'b0;
      endcase
   endfunction

   task automatic checkOutput();
      exp_t e;
      total++;
      assert (exp_q.size() > 0) else begin
         bad++;
         $error("[TB] FAIL scoreboard_empty observed=0 expected>0");
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         assert (PC === e.pc) else begin
            bad++;
            $error("[TB] FAIL %s.PC observed=%h expected=%h", e.tag, PC, e.pc);
         end
         total++;
         assert (branch_control === e.bc) else begin
            bad++;
            $error("[TB] FAIL %s.branch_control observed=%b expected=%b", e.tag, branch_control, e.bc);
         end
         total++;
         assert (write_reg === e.wr) else begin
            bad++;
            $error("[TB] FAIL %s.write_reg observed=%b expected=%b", e.tag, write_reg, e.wr);
         end
      end
   endtask

   task automatic applyStimulus(input string tag, input logic r, input logic [5:0] c,
                                input logic z, input logic cy, input logic s, input logic v,
                                input logic [31:0] lit, input logic [31:0] ra);
      exp_t e;
      logic t;
      rst = r; bcode = c; zflag = z; carryflag = cy; signflag = s; ovfflag = v;
      L = lit; rega = ra;
      t = model_taken(c, z, cy, s, v);
      e.tag = tag;
      if (r) begin
         model_pc = 11'd0;
         e.bc = 1'b0;
         e.wr = 1'b0;
      end else begin
         if (t)
            model_pc = (c == 6'b100000) ? ra[10:0] : lit[10:0];
         e.bc = t;
         e.wr = t && (c == 6'b100010);
      end
      e.pc = model_pc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      logic [5:0] code;
      model_pc = 11'd0;
      @(negedge clk);
      applyStimulus("reset0", 1'b1, 6'b101000, 1, 0, 0, 0, 32'd235, 32'd5);
      applyStimulus("reset1", 1'b1, 6'b101000, 1, 0, 0, 0, 32'd235, 32'd5);
      applyStimulus("bz_taken", 1'b0, 6'b101000, 1, 0, 0, 0, 32'd235, 32'd5);
      applyStimulus("bz_not", 1'b0, 6'b101000, 0, 0, 0, 0, 32'd77, 32'd5);
      applyStimulus("bnz_taken", 1'b0, 6'b101001, 0, 0, 0, 0, 32'd40, 32'd5);
      applyStimulus("br", 1'b0, 6'b100000, 0, 0, 0, 0, 32'd40, 32'd5);
      applyStimulus("call", 1'b0, 6'b100010, 0, 0, 0, 0, 32'd300, 32'd5);
      applyStimulus("nonbranch", 1'b0, 6'b000000, 1, 1, 1, 1, 32'd999, 32'd9);
      applyStimulus("nonbranch_flags", 1'b0, 6'b110000, 0, 1, 0, 1, 32'd12, 32'd13);
      for (int i = 2; i < 8; i++) begin
         code = 6'b101000 | 6'(i);
         for (int f = 1; f >= 0; f--) begin
            applyStimulus($sformatf("sweep_%b_f%0d", code, f), 1'b0, code,
                          1'b0,
                          (i / 2 == 1) ? f[0] : 1'b0,
                          (i / 2 == 2) ? f[0] : 1'b0,
                          (i / 2 == 3) ? f[0] : 1'b0,
                          32'd100 + 32'(i * 2 + f), 32'd7);
         end
      end
      applyStimulus("trunc_b", 1'b0, 6'b100001, 0, 0, 0, 0, 32'h0000_0FFF, 32'd3);
      applyStimulus("trunc_br", 1'b0, 6'b100000, 0, 0, 0, 0, 32'd1, 32'hFFFF_F123);
      applyStimulus("reserved", 1'b0, 6'b100101, 1, 1, 1, 1, 32'd55, 32'd66);
      applyStimulus("reserved2", 1'b0, 6'b100111, 0, 0, 0, 0, 32'd56, 32'd67);
      applyStimulus("b2b_0", 1'b0, 6'b100001, 0, 0, 0, 0, 32'd10, 32'd0);
      applyStimulus("b2b_1", 1'b0, 6'b100010, 0, 0, 0, 0, 32'd20, 32'd0);
      applyStimulus("b2b_2", 1'b0, 6'b101110, 0, 0, 0, 1, 32'd30, 32'd0);
      applyStimulus("reset_mid", 1'b1, 6'b100010, 0, 0, 0, 0, 32'd44, 32'd0);
      applyStimulus("after_reset", 1'b0, 6'b101011, 0, 1, 0, 0, 32'd45, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
